rtc_bus_cycle: RTL and testbench
================================

# rtc_bus_cycle

Transaction generator for the RTC chip's multiplexed address/data bus: runs one complete read or write access (address phase, then data phase) with programmable strobe widths. It sits directly upstream of the three-input OR combiners, which merge its active-high `cs_req` / `wr_req` / `rd_req` requests with those of the init and refresh generators before the board-level pin drivers. It also drives the bus value and output enable for its own accesses, and returns read data.

## Interface
- `PHASE_CYC`, default 10: clock cycles per phase (100 ns at 100 MHz). Legal range is 1..255.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a transaction; sampled only in IDLE.
- `rw` input 1: transaction type, 1 = read, 0 = write. Captured with `start`.
- `addr` input 8: RTC register address. Captured with `start`.
- `wdata` input 8: write data. Captured with `start`.
- `ad_in` input 8: bus value sampled from the pins.
- `busy` output 1: a transaction is in progress.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 8: last read result. Holds its value until the next read or reset.
- `cs_req` output 1: chip-select request, to the OR combiner.
- `wr_req` output 1: write-strobe request, to the OR combiner.
- `rd_req` output 1: read-strobe request, to the OR combiner.
- `addr_phase` output 1: 1 = address phase (A/D pin low downstream).
- `bus_oe` output 1: drive the bus.
- `bus_out` output 8: value to drive onto the bus.

## Operation
- States: IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, plus GAP when configured. Each non-IDLE state lasts exactly `PHASE_CYC` cycles, timed by an 8-bit down-counter reloaded on every state entry.
- IDLE to A_SET: on `start`=1. On that same edge, `rw`, `addr` and `wdata` are latched.
- Sequence: A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, then GAP (if enabled), then IDLE.
- `start` is ignored outside IDLE. It has no effect and is not queued.
- All request and bus outputs are registered, decoded from the next state, so they are glitch-free at the combiners.
- `cs_req` = 1 in A_SET through D_HLD; 0 in GAP and IDLE.
- `addr_phase` = 1 in A_SET, A_STB and A_HLD.
- `wr_req` = 1 in A_STB for every transaction, and in D_STB for writes only.
- `rd_req` = 1 in D_STB for reads only.
- `bus_oe` = 1 in A_SET..A_HLD. It is also 1 in D_SET..D_HLD for writes; it is 0 in the data phase of a read.
- `bus_out` = latched `addr` in the address phase, latched `wdata` in the data phase of a write, and 0x00 otherwise.
- Read capture: `rdata` loads `ad_in` on the edge that ends the last D_STB cycle. Writes never change `rdata`.
- `busy` = 1 in every non-IDLE state.
- `done` = 1 for exactly the first IDLE cycle after the sequence ends. `start` is accepted in that cycle.

## Timing
- Reset values: `busy`, `done`, `cs_req`, `wr_req`, `rd_req`, `addr_phase` and `bus_oe` are 0; `rdata` = 0x00; `bus_out` = 0x00; state = IDLE.
- Cycle numbering: cycle 0 is the edge at which `start` is sampled. Phase n (n = 0..5) occupies cycles n·P+1 through (n+1)·P, where P = `PHASE_CYC`.
- `done` falls at 6P+1 without GAP and at 7P+1 with GAP. `busy` is 0 in the `done` cycle.
- Minimum start-to-start spacing is 6P+1 cycles without GAP and 7P+1 with GAP.
- With P = 1, every phase lasts one cycle and the counter never underflows.
- Reset mid-transaction: every output goes to its reset value immediately (asynchronously). There is no `done` pulse, and the partial read is discarded.

## Configuration
- `RTC_CYCLE_GAP_EN` defined: the GAP state is compiled in. It lasts P cycles with all requests low and `busy` = 1, which guarantees chip-select recovery between back-to-back accesses.
- `RTC_CYCLE_GAP_EN` not defined: GAP is absent, and D_HLD goes directly to IDLE.

## Test plan
All scenarios use P = 2 and no GAP unless stated.
- Write, `addr`=0x21, `wdata`=0x45: `addr_phase` high cycles 1–6 with `bus_out`=0x21; `wr_req` high cycles 3–4 and 9–10; `bus_out`=0x45 in cycles 7–12; `rd_req` never high; `done` at cycle 13.
- Read, `addr`=0x22, `ad_in`=0x5A in cycle 10: `rd_req` high cycles 9–10; `bus_oe` low in cycles 7–12; `rdata`=0x5A at cycle 13 together with `done`.
- `start` pulsed at cycle 5 with different `addr` during a write: the transaction is unchanged, still ends at cycle 13, and no second transaction starts.
- `start` held high continuously: a second transaction begins at edge 13; `done` pulses at 13 and 26; `done` is never high for two consecutive cycles.
- `reset_n` low at cycle 5 of a read: all outputs are 0 in the same cycle; no `done` pulse; `rdata`=0x00.
- With `RTC_CYCLE_GAP_EN` defined: `cs_req` falls after cycle 12; `busy` stays high through cycle 14; `done` at cycle 15.

Source files
------------

// File: rtl/rtc_bus_cycle.sv
// Read/write transaction generator for the RTC multiplexed address/data bus.
// Optional chip-select recovery state after each access: define RTC_CYCLE_GAP_EN.
//
// state  | meaning
// IDLE   | waiting for start
// A_SET  | address driven, setup before strobe
// A_STB  | address latch strobe (wr_req)
// A_HLD  | address held after strobe
// D_SET  | data phase setup (write data driven, or bus released for read)
// D_STB  | data strobe (wr_req for write, rd_req for read)
// D_HLD  | data phase hold
// GAP    | chip-select recovery, all requests low (RTC_CYCLE_GAP_EN only)
module rtc_bus_cycle #(
  parameter int PHASE_CYC = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_req,
  output logic       wr_req,
  output logic       rd_req,
  output logic       addr_phase,
  output logic       bus_oe,
  output logic [7:0] bus_out
);

  typedef enum logic [2:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP
  } state_t;

  localparam logic [7:0] RELOAD = 8'(PHASE_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       rw_q;
  logic [7:0] addr_q, wdata_q;
  logic       accept, phase_end;

  logic       rw_nxt;
  logic [7:0] addr_nxt, wdata_nxt;
  logic       busy_d, done_d, cs_d, wr_d, rd_d, ap_d, oe_d;
  logic [7:0] bus_out_d;

  assign accept    = (state == IDLE) && start;
  assign phase_end = (cnt == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      rw_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rdata      <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      cs_req     <= 1'b0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      addr_phase <= 1'b0;
      bus_oe     <= 1'b0;
      bus_out    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= RELOAD;
      else if (!phase_end)
        cnt <= cnt - 8'd1;
      rw_q    <= rw_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      // Capture on the edge that closes the final strobe cycle of a read.
      if (state == D_STB && phase_end && rw_q)
        rdata <= ad_in;
      busy       <= busy_d;
      done       <= done_d;
      cs_req     <= cs_d;
      wr_req     <= wr_d;
      rd_req     <= rd_d;
      addr_phase <= ap_d;
      bus_oe     <= oe_d;
      bus_out    <= bus_out_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start)     state_nxt = A_SET;
      A_SET: if (phase_end) state_nxt = A_STB;
      A_STB: if (phase_end) state_nxt = A_HLD;
      A_HLD: if (phase_end) state_nxt = D_SET;
      D_SET: if (phase_end) state_nxt = D_STB;
      D_STB: if (phase_end) state_nxt = D_HLD;
`ifdef RTC_CYCLE_GAP_EN
      D_HLD: if (phase_end) state_nxt = GAP;
      GAP:   if (phase_end) state_nxt = IDLE;
`else
      D_HLD: if (phase_end) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state (and freshly latched fields) so
  // the registered requests line up with the state they describe.
  always_comb begin
    rw_nxt    = accept ? rw    : rw_q;
    addr_nxt  = accept ? addr  : addr_q;
    wdata_nxt = accept ? wdata : wdata_q;
    busy_d    = (state_nxt != IDLE);
    done_d    = (state != IDLE) && (state_nxt == IDLE);
    ap_d      = (state_nxt == A_SET) || (state_nxt == A_STB) || (state_nxt == A_HLD);
    cs_d      = ap_d || (state_nxt == D_SET) || (state_nxt == D_STB) || (state_nxt == D_HLD);
    wr_d      = (state_nxt == A_STB) || ((state_nxt == D_STB) && !rw_nxt);
    rd_d      = (state_nxt == D_STB) && rw_nxt;
    oe_d      = ap_d || (cs_d && !rw_nxt);
    bus_out_d = 8'h00;
    if (ap_d)
      bus_out_d = addr_nxt;
    else if (cs_d && !rw_nxt)
      bus_out_d = wdata_nxt;
  end

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Directed scoreboard bench for rtc_bus_cycle with PHASE_CYC = 2.
module tb_rtc_bus_cycle;

  localparam int P = 2;
`ifdef RTC_CYCLE_GAP_EN
  localparam int LAST = 7 * P;
`else
  localparam int LAST = 6 * P;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] ad_in = 8'hFF;
  logic       busy, done, cs_req, wr_req, rd_req, addr_phase, bus_oe;
  logic [7:0] rdata, bus_out;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_rdata = 8'h00;
  logic [22:0] sb[$];

  rtc_bus_cycle #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .ad_in(ad_in), .busy(busy), .done(done), .rdata(rdata),
    .cs_req(cs_req), .wr_req(wr_req), .rd_req(rd_req),
    .addr_phase(addr_phase), .bus_oe(bus_oe), .bus_out(bus_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // {busy, done, cs, wr, rd, addr_phase, oe, bus_out, rdata}
  function automatic logic [22:0] idle_vec(input logic d, input logic [7:0] rd);
    return {1'b0, d, 5'b0, 8'h00, rd};
  endfunction

  // Expected outputs in cycle k (1-based, edge 0 samples start).
  function automatic logic [22:0] exp_vec(input int k, input bit t_rw,
                                          input logic [7:0] a, input logic [7:0] w,
                                          input logic [7:0] rd);
    int ph;
    logic dph;
    ph = (k - 1) / P;
    if (k == LAST + 1) return idle_vec(1'b1, rd);
    if (ph >= 6) return {1'b1, 1'b0, 5'b0, 8'h00, rd};
    dph = (ph >= 3);
    return {1'b1, 1'b0, 1'b1,
            (ph == 1) || (ph == 4 && !t_rw),
            (ph == 4 && t_rw),
            !dph,
            !dph || !t_rw,
            !dph ? a : (!t_rw ? w : 8'h00),
            rd};
  endfunction

  function automatic logic [22:0] observed();
    return {busy, done, cs_req, wr_req, rd_req, addr_phase, bus_oe, bus_out, rdata};
  endfunction

  task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check(tag, observed(), idle_vec(1'b0, exp_rdata));
    end
  endtask

  // Called at a negedge; the following posedge is edge 0 of the transaction.
  task automatic run_txn(input bit t_rw, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                         input logic [7:0] t_rdval, input bit hold, input int stray_at,
                         input int abort_at, input string tag);
    logic [7:0] rd_after;
    rd_after = t_rw ? t_rdval : exp_rdata;
    for (int k = 1; k <= LAST + 1; k++)
      sb.push_back(exp_vec(k, t_rw, t_addr, t_wdata, (k > 5 * P) ? rd_after : exp_rdata));
    start = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata; ad_in = 8'hFF;
    for (int k = 1; k <= LAST + 1; k++) begin
      @(posedge clk); @(negedge clk);
      check(tag, observed(), sb.pop_front());
      if (k == abort_at) begin
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        exp_rdata = 8'h00;
        check({tag, "_async_rst"}, observed(), idle_vec(1'b0, 8'h00));
        sb.delete();
        return;
      end
      start = hold || (k == stray_at);
      if (k == stray_at) begin
        addr = 8'h99; wdata = 8'hEE; rw = ~t_rw;
      end
      ad_in = (k == 5 * P) ? t_rdval : 8'hFF;
    end
    exp_rdata = rd_after;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", observed(), idle_vec(1'b0, 8'h00));
    reset_n = 1'b1;
    idle_check(2, "idle_after_reset");

    run_txn(1'b0, 8'h21, 8'h45, 8'h00, 1'b0, 0, 0, "write_21_45");
    idle_check(2, "idle_after_write");

    run_txn(1'b1, 8'h22, 8'h00, 8'h5A, 1'b0, 0, 0, "read_22");
    idle_check(2, "idle_after_read");

    run_txn(1'b0, 8'h33, 8'h66, 8'h00, 1'b0, 5, 0, "write_stray_start");
    idle_check(3, "no_queued_start");

    run_txn(1'b1, 8'h44, 8'h00, 8'hA5, 1'b1, 0, 0, "held_start_read");
    run_txn(1'b0, 8'h55, 8'h77, 8'h00, 1'b0, 0, 0, "held_start_write");
    idle_check(2, "idle_after_b2b");

    run_txn(1'b1, 8'h10, 8'h00, 8'h3C, 1'b0, 0, 5, "read_abort");
    idle_check(2, "held_in_reset");
    reset_n = 1'b1;
    idle_check(3, "no_done_after_abort");

    run_txn(1'b1, 8'h7F, 8'h00, 8'hC3, 1'b0, 0, 0, "read_after_abort");
    idle_check(1, "idle_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
